// File: rtl/fp_add_result_queue.sv
// Writeback stage behind the single-precision FP adder: repairs IEEE-754 special cases
// the adder ignores, queues results with exception flags and keeps sticky flags.
module fp_add_result_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_a,
   input  logic [XLEN-1:0]          in_b,
   input  logic [XLEN-1:0]          in_sum,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_data,
   output logic [3:0]               out_flags,
   output logic [3:0]               fflags,
   input  logic                     fflags_clr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic       sign_a, sign_b;
   logic [7:0] exp_a, exp_b, exp_sum, max_exp;
   logic       nan_a, nan_b, snan_a, snan_b;
   logic       inf_a, inf_b, zero_a, zero_b;

   logic [XLEN-1:0] res_data;
   logic [3:0]      res_flags;

   logic [XLEN+3:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            push, pop;

   assign sign_a  = in_a[31];
   assign sign_b  = in_b[31];
   assign exp_a   = in_a[30:23];
   assign exp_b   = in_b[30:23];
   assign exp_sum = in_sum[30:23];
   assign max_exp = (exp_a > exp_b) ? exp_a : exp_b;

   assign nan_a  = (exp_a == 8'hFF) && (in_a[22:0] != 23'd0);
   assign nan_b  = (exp_b == 8'hFF) && (in_b[22:0] != 23'd0);
   assign snan_a = nan_a && !in_a[22];
   assign snan_b = nan_b && !in_b[22];
   assign inf_a  = (exp_a == 8'hFF) && (in_a[22:0] == 23'd0);
   assign inf_b  = (exp_b == 8'hFF) && (in_b[22:0] == 23'd0);
   // Denormal operands are flushed to zero, so only the exponent matters here.
   assign zero_a = (exp_a == 8'd0);
   assign zero_b = (exp_b == 8'd0);

   // Special-case repair in priority order; flags are {NV, OF, UF, NX}.
   always_comb begin
      res_data  = in_sum;
      res_flags = 4'b0000;
      if (nan_a || nan_b) begin
         res_data  = 32'h7FC0_0000;
         res_flags = {snan_a || snan_b, 3'b000};
      end else if (inf_a && inf_b && (sign_a != sign_b)) begin
         res_data  = 32'h7FC0_0000;
         res_flags = 4'b1000;
      end else if (inf_a) begin
         res_data = in_a;
      end else if (inf_b) begin
         res_data = in_b;
      end else if (zero_a && zero_b) begin
         res_data = {sign_a & sign_b, 31'd0};
      end else if (zero_a) begin
         res_data = in_b;
      end else if (zero_b) begin
         res_data = in_a;
      end else if ((sign_a != sign_b) && (in_a[30:0] == in_b[30:0])) begin
         res_data = 32'h0000_0000;
      end else if ((sign_a == sign_b) && (exp_sum == 8'hFF)) begin
         res_data  = {sign_a, 8'hFF, 23'd0};
         res_flags = 4'b0101;
      end else if ((sign_a != sign_b) && (exp_sum > max_exp)) begin
         res_data  = {in_sum[31], 31'd0};
         res_flags = 4'b0011;
      end
   end

   // in_ready deliberately ignores out_ready so a full queue never accepts.
   assign in_ready  = !rst && (count != (AW+1)'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_data  = out_valid ? mem[rd_ptr][XLEN-1:0] : '0;
   assign out_flags = out_valid ? mem[rd_ptr][XLEN+3:XLEN] : 4'b0000;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {res_flags, res_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         fflags <= 4'b0000;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         fflags <= (fflags_clr ? 4'b0000 : fflags) | (pop ? out_flags : 4'b0000);
      end
   end

endmodule

// File: tb/tb_fp_add_result_queue.sv
// Self-checking bench for fp_add_result_queue: directed special cases and randomized
// traffic compared every cycle against a queue-based reference model.
module tb_fp_add_result_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, fflags_clr;
   logic [31:0] in_a, in_b, in_sum, out_data;
   logic [3:0]  out_flags, fflags;
   logic [2:0]  count;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  flags;
   } entry_t;

   entry_t     model_q[$];
   logic [3:0] model_fflags;
   int         checks = 0;
   int         errors = 0;

   fp_add_result_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_flags(out_flags),
      .fflags(fflags), .fflags_clr(fflags_clr), .count(count)
   );

   always #5 clk = ~clk;

   function automatic bit isNaN(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction

   function automatic bit isInf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 0);
   endfunction

   function automatic bit isZero(input logic [31:0] x);
      return x[30:23] == 8'h00;
   endfunction

   // Reference IEEE repair, stated rule by rule with early exits.
   function automatic entry_t refResult(input logic [31:0] a, b, s);
      entry_t e;
      bit     same_sign = (a[31] == b[31]);
      int     max_exp   = (int'(a[30:23]) > int'(b[30:23])) ? int'(a[30:23]) : int'(b[30:23]);
      e.flags = 4'b0000;
      if (isNaN(a) || isNaN(b)) begin
         e.data = 32'h7FC00000;
         if ((isNaN(a) && a[22] == 1'b0) || (isNaN(b) && b[22] == 1'b0)) e.flags = 4'b1000;
         return e;
      end
      if (isInf(a) && isInf(b) && !same_sign) begin
         e.data = 32'h7FC00000; e.flags = 4'b1000; return e;
      end
      if (isInf(a)) begin e.data = a; return e; end
      if (isInf(b)) begin e.data = b; return e; end
      if (isZero(a) && isZero(b)) begin
         e.data = (a[31] && b[31]) ? 32'h80000000 : 32'h00000000; return e;
      end
      if (isZero(a)) begin e.data = b; return e; end
      if (isZero(b)) begin e.data = a; return e; end
      if (!same_sign && (a & 32'h7FFFFFFF) == (b & 32'h7FFFFFFF)) begin
         e.data = 32'h0; return e;
      end
      if (same_sign && s[30:23] == 8'hFF) begin
         e.data = a[31] ? 32'hFF800000 : 32'h7F800000; e.flags = 4'b0101; return e;
      end
      if (!same_sign && int'(s[30:23]) > max_exp) begin
         e.data = s[31] ? 32'h80000000 : 32'h00000000; e.flags = 4'b0011; return e;
      end
      e.data = s;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkState();
      logic [31:0] exp_data  = 32'h0;
      logic [3:0]  exp_flags = 4'h0;
      if (model_q.size() != 0) begin
         exp_data  = model_q[0].data;
         exp_flags = model_q[0].flags;
      end
      checkOutput("count", 32'(count), 32'(model_q.size()));
      checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      checkOutput("out_data", out_data, exp_data);
      checkOutput("out_flags", 32'(out_flags), 32'(exp_flags));
      checkOutput("fflags", 32'(fflags), 32'(model_fflags));
   endtask

   // One clock cycle of traffic: drive, check in_ready, advance model, check outputs.
   task automatic applyStimulus(input logic v, input logic [31:0] a, b, s,
                                input logic r, input logic clr);
      entry_t e;
      bit     acc, pp;
      in_valid = v; in_a = a; in_b = b; in_sum = s; out_ready = r; fflags_clr = clr;
      #1;
      checkOutput("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
      acc = v && (model_q.size() != DEPTH);
      pp  = r && (model_q.size() != 0);
      e   = refResult(a, b, s);
      @(posedge clk);
      #1;
      if (pp) begin
         model_fflags = (clr ? 4'b0000 : model_fflags) | model_q[0].flags;
         void'(model_q.pop_front());
      end else if (clr) begin
         model_fflags = 4'b0000;
      end
      if (acc) model_q.push_back(e);
      checkState();
   endtask

   task automatic applyReset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; fflags_clr = 1'b0;
      in_a = 32'h3F800000; in_b = 32'h3F800000; in_sum = 32'h40000000;
      #1;
      checkOutput("in_ready_in_reset", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_q.delete();
      model_fflags = 4'b0000;
      checkState();
   endtask

   function automatic logic [31:0] randOperand();
      logic [31:0] x = $urandom;
      case ($urandom_range(0, 11))
         0:       x = {x[31], 8'hFF, 23'd0};
         1:       x = {x[31], 8'hFF, 1'b1, x[21:0]};
         2:       x = {x[31], 8'hFF, 1'b0, x[21:1], 1'b1};
         3:       x = {x[31], 31'd0};
         4:       x = {x[31], 8'h00, x[22:0]};
         default: x = x;
      endcase
      return x;
   endfunction

   initial begin
      logic [31:0] ra, rb, rs;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
      in_a = '0; in_b = '0; in_sum = '0;
      model_fflags = 4'b0000;

      applyReset();
      applyStimulus(1, 32'h3F800000, 32'h40000000, 32'h40400000, 1, 0);
      applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);

      applyStimulus(1, 32'h7F800000, 32'hFF800000, 32'h12345678, 0, 0);
      applyStimulus(1, 32'h7F800001, 32'h3F800000, 32'h3F800000, 0, 0);
      applyStimulus(1, 32'h3F800000, 32'hBF800000, 32'h00000000, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);

      applyReset();
      applyStimulus(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 0, 0);
      applyStimulus(1, 32'h3F800000, 32'hBF7FFFFF, 32'h7F000000, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);

      applyReset();
      for (int i = 0; i < 5; i++)
         applyStimulus(1, 32'h3F800000, 32'h3F800000, 32'h40000000 + i, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);

      applyStimulus(1, 32'h40000000, 32'h40000000, 32'h40800000, 0, 0);
      applyStimulus(1, 32'h40000000, 32'h40400000, 32'h40A00000, 0, 0);
      for (int i = 0; i < 10; i++)
         applyStimulus(1, 32'h3F800000, 32'h40000000, 32'h41000000 + i, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);

      applyReset();
      applyStimulus(1, 32'h7F800000, 32'hFF800000, 32'h0, 1, 0);
      applyStimulus(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1, 0);
      applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 1);

      for (int i = 0; i < 3; i++)
         applyStimulus(1, 32'h40000000, 32'h3F800000, 32'h40400000, 0, 0);
      applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);
      applyReset();

      for (int i = 0; i < 600; i++) begin
         ra = randOperand();
         rb = ($urandom_range(0, 7) == 0) ? (ra ^ 32'h80000000) : randOperand();
         rs = $urandom;
         if ($urandom_range(0, 3) == 0) rs[30:23] = 8'hFF;
         applyStimulus(1'($urandom_range(0, 3) != 0), ra, rb, rs,
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
      end
      for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fp_add_result_queue.md
# fp_add_result_queue

Writeback stage directly downstream of the single-precision FP adder. Each cycle it can capture the adder's combinational result together with the two operands that produced it. It repairs IEEE-754 special cases the adder does not handle: NaN, infinity, zero, overflow and underflow. It then queues the final result with per-operation exception flags in a small FIFO, drains it over a valid/ready handshake, and accumulates sticky flags.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  adder result and operands are valid this cycle.
- in_ready  out  1  queue can accept an entry.
- in_a  in  XLEN  operand A as presented to the adder.
- in_b  in  XLEN  operand B as presented to the adder.
- in_sum  in  XLEN  raw adder result for in_a + in_b.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head entry.
- out_data  out  XLEN  corrected result at head.
- out_flags  out  4  head flags {NV, OF, UF, NX}.
- fflags  out  4  sticky OR of flags of all popped entries.
- fflags_clr  in  1  clear sticky flags.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Classification is combinational on the inputs and is stored with the entry. Rules are evaluated in priority order; the first matching rule wins:
  1. Either operand NaN (exp 0xFF, mantissa != 0): result 0x7FC00000. NV is set if either operand has mantissa bit 22 = 0 (signalling NaN).
  2. Both operands infinite with opposite signs: result 0x7FC00000, NV.
  3. Exactly one operand infinite, or both infinite with the same sign: result is that infinity, no flags.
  4. Both operands zero (exp 0, mantissa 0): result +0. The result is -0 only if both operands are -0.
  5. One operand zero: result is the other operand unchanged.
  6. Signs differ and magnitude bits [30:0] are equal: result 0x00000000.
  7. Signs equal and in_sum[30:23] == 0xFF: result {sign, 0x7F800000[30:0]}, flags OF and NX.
  8. Signs differ and in_sum[30:23] > max(exp_a, exp_b) (exponent wrapped): result {sign of in_sum, 31'b0}, flags UF and NX.
  9. Otherwise: result in_sum, no flags.
- Operands with exponent 0 and nonzero mantissa (denormals) are treated as zero for rules 4/5.
- FIFO: circular buffer with read and write pointers that wrap at DEPTH. Simultaneous push and pop leaves count unchanged and is legal at any occupancy except full.
- in_ready = (count != DEPTH). There is no combinational path from out_ready to in_ready, so a full queue does not accept an entry even when a pop happens in the same cycle.
- out_valid = (count != 0). out_data and out_flags show the head entry and hold stable while out_valid && !out_ready.
- fflags next value = (fflags_clr ? 0 : fflags) | (pop ? out_flags : 0). Clear and pop in the same cycle leaves only the popped flags.

## Timing
- Reset values: count 0, pointers 0, out_valid 0, out_data 0, out_flags 0, fflags 0. in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Latency: an entry accepted at edge N is visible at the head (out_valid=1) after edge N when the queue was empty. Minimum latency is 1 cycle.
- Throughput: 1 entry per cycle sustained when out_ready is held high.
- Reset mid-operation discards all entries and clears fflags. Any push or pop in the reset cycle is ignored.
- Inputs are sampled only on accept. in_sum must already be settled in the accept cycle because the adder is combinational.

## Test plan
- Basic: push a=0x3F800000, b=0x40000000, sum=0x40400000 with out_ready=1 -> next cycle out_data=0x40400000, out_flags=0, count=1, then 0.
- Specials: push (0x7F800000, 0xFF800000) -> 0x7FC00000 with NV. Push (0x7F800001, 0x3F800000) -> 0x7FC00000 with NV. Push (0x3F800000, 0xBF800000) -> 0x00000000, no flags.
- Overflow/underflow: push (0x7F7FFFFF, 0x7F7FFFFF, sum exp 0xFF) -> 0x7F800000 with OF|NX. Push a subtract whose sum exponent wraps above the operand exponents -> signed zero with UF|NX. Check fflags=4'b0111 after both are popped.
- Full/backpressure: out_ready=0, push 5 entries -> in_ready=0 after 4 accepts and count=4. The 5th entry must not be stored. Raise out_ready -> data drains in order.
- Simultaneous push/pop at count=2 for 10 cycles -> count stays 2, pointers wrap, and order is preserved.
- Assert fflags_clr in the same cycle as popping an OF entry with fflags=NV -> fflags=OF|NX. Assert rst with 3 entries queued -> count=0, out_valid=0, fflags=0 on the next cycle.
